// File: rtl/load_unit_pkg.sv
// load_unit_pkg: shared func3 codes, FSM state and access-size types for the load path
// Exports F3_* store/load codes, load_state_t, ld_size_t and ld_size().
// REQ2/WAIT2 states exist only when LOAD_MISALIGNED_SPLIT_EN is defined.
package load_unit_pkg;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_DONE
`ifdef LOAD_MISALIGNED_SPLIT_EN
      ,
      S_REQ2,
      S_WAIT2
`endif
   } load_state_t;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} ld_size_t;

   // Any func3 that is not a byte or halfword load is handled as a word load.
   function automatic ld_size_t ld_size(input logic [2:0] f3);
      return f3[1:0] == 2'b00 ? SZ_B : f3[1:0] == 2'b01 ? SZ_H : SZ_W;
   endfunction

endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: word-aligned read channel between the load unit and data memory
// mem_req/mem_addr   : read request and word address (load unit -> memory)
// mem_ready          : request accepted when mem_req & mem_ready
// mem_rvalid/rdata   : read response (memory -> load unit)
interface load_unit_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ready;
   logic                  mem_rvalid;
   logic [31:0]           mem_rdata;

   modport master (output mem_req, mem_addr, input mem_ready, mem_rvalid, mem_rdata);
   modport slave  (input mem_req, mem_addr, output mem_ready, mem_rvalid, mem_rdata);

endinterface

// File: rtl/load_extract.sv
// load_extract: selects the byte/halfword/word of a read word and sign/zero extends it
// word_i  : read word (or pre-shifted split pair)
// off_i   : byte offset of the access within word_i
// func3_i : load type, bit 2 selects zero extension
// data_o  : extended result
module load_extract
   import load_unit_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  func3_i,
   output logic [31:0] data_o
);

   logic [31:0] sh;
   ld_size_t    sz;

   // Shifting by the byte offset puts the addressed data in the low bits for every size.
   assign sh = word_i >> {off_i, 3'b000};
   assign sz = ld_size(func3_i);

   assign data_o = sz == SZ_B ? {{24{sh[7] & ~func3_i[2]}}, sh[7:0]} :
                   sz == SZ_H ? {{16{sh[15] & ~func3_i[2]}}, sh[15:0]} : sh;

endmodule

// File: rtl/load_unit.sv
// load_unit: memory-stage load path issuing word reads and extending the selected data
// clk, reset_n          : clock, asynchronous active-low reset
// load_req, addr, func3 : one-cycle load request accepted in IDLE
// flush                 : abort the load in flight
// stall_out             : hold the upstream pipeline
// load_valid/data/err   : one-cycle completion with result or misaligned/timeout error
// mem                   : read channel (load_unit_if.master)
// WAIT_LIMIT            : cycles allowed in a wait state before a timeout, 0 disables
// LOAD_MISALIGNED_SPLIT_EN : when defined, misaligned loads are served by one or two reads
module load_unit
   import load_unit_pkg::*;
#(
   parameter int WAIT_LIMIT = 255,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load_req,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            func3,
   input  logic                  flush,
   output logic                  stall_out,
   output logic                  load_valid,
   output logic [31:0]           load_data,
   output logic                  load_err,
   load_unit_if.master           mem
);

   localparam int CW = WAIT_LIMIT > 0 ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW:0] LIM = (CW + 1)'(WAIT_LIMIT);

   load_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            f3_q, f3_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [31:0]           data_q, data_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [31:0]           ext_word, ext_data;
   logic [1:0]            ext_off;
   logic                  mis, timeout;

   assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   // The counter holds the number of completed wait cycles minus one at the last allowed cycle.
   assign timeout   = (WAIT_LIMIT != 0) && ({1'b0, cnt_q} + (CW + 1)'(1) == LIM);

`ifdef LOAD_MISALIGNED_SPLIT_EN
   logic [31:0] word0_q, word0_d;
   logic [31:0] pair;
   logic        split;
   assign mis   = 1'b0;
   assign split = (ld_size(f3_q) == SZ_W && addr_q[1:0] != 2'b00) ||
                  (ld_size(f3_q) == SZ_H && addr_q[1:0] == 2'b11);
   // {second, first} shifted so the addressed bytes start at bit 0.
   assign pair     = 32'({mem.mem_rdata, word0_q} >> {addr_q[1:0], 3'b000});
   assign ext_word = state_q == S_WAIT2 ? pair : mem.mem_rdata;
   assign ext_off  = state_q == S_WAIT2 ? 2'b00 : addr_q[1:0];
   assign mem.mem_req  = state_q == S_REQ || state_q == S_REQ2;
   assign mem.mem_addr = state_q == S_REQ2 ? word_addr + ADDR_WIDTH'(4) : word_addr;
`else
   ld_size_t req_sz;
   assign req_sz   = ld_size(func3);
   assign mis      = req_sz == SZ_W ? addr[1:0] != 2'b00 : req_sz == SZ_H && addr[0];
   assign ext_word = mem.mem_rdata;
   assign ext_off  = addr_q[1:0];
   assign mem.mem_req  = state_q == S_REQ;
   assign mem.mem_addr = word_addr;
`endif

   load_extract u_extract (
      .word_i  (ext_word),
      .off_i   (ext_off),
      .func3_i (f3_q),
      .data_o  (ext_data)
   );

   assign stall_out  = state_q == S_IDLE ? load_req : state_q != S_DONE;
   assign load_valid = state_q == S_DONE;
   assign load_err   = load_valid & err_q;
   assign load_data  = data_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      cnt_d   = cnt_q + CW'(1);
      data_d  = data_q;
      err_d   = err_q;
`ifdef LOAD_MISALIGNED_SPLIT_EN
      word0_d = word0_q;
`endif
      case (state_q)
         S_IDLE: if (load_req) begin
            addr_d  = addr;
            f3_d    = func3;
            err_d   = mis;
            data_d  = mis ? 32'h0 : data_q;
            state_d = mis ? S_DONE : S_REQ;
         end
         S_REQ: begin
            if (flush) state_d = S_IDLE;
            else if (mem.mem_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (flush) state_d = S_DRAIN;
`ifdef LOAD_MISALIGNED_SPLIT_EN
            else if (mem.mem_rvalid && split) begin
               word0_d = mem.mem_rdata;
               state_d = S_REQ2;
            end
`endif
            else if (mem.mem_rvalid) begin
               data_d  = ext_data;
               state_d = S_DONE;
            end else if (timeout) begin
               data_d  = 32'h0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
`ifdef LOAD_MISALIGNED_SPLIT_EN
         S_REQ2: begin
            if (flush) state_d = S_IDLE;
            else if (mem.mem_ready) begin
               state_d = S_WAIT2;
               cnt_d   = '0;
            end
         end
         S_WAIT2: begin
            if (flush) state_d = S_DRAIN;
            else if (mem.mem_rvalid) begin
               data_d  = ext_data;
               state_d = S_DONE;
            end else if (timeout) begin
               data_d  = 32'h0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
`endif
         // One response is still owed after a flush in a wait state; swallow it.
         S_DRAIN: if (mem.mem_rvalid || timeout) state_d = S_IDLE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
         word0_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
`ifdef LOAD_MISALIGNED_SPLIT_EN
         word0_q <= word0_d;
`endif
      end
   end

   a_req_in_idle: assert property (@(posedge clk) disable iff (!reset_n) load_req |-> state_q == S_IDLE);

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed vectors and corner-case sequences for load_unit
module tb_load_unit;
   import load_unit_pkg::*;

   logic        clk = 1'b0, reset_n = 1'b0, load_req = 1'b0, flush = 1'b0;
   logic [31:0] addr = '0;
   logic [2:0]  func3 = '0;
   logic        stall_out, load_valid, load_err;
   logic [31:0] load_data;

   load_unit_if #(.ADDR_WIDTH(32)) mif ();

   load_unit #(.WAIT_LIMIT(8), .ADDR_WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_req   (load_req),
      .addr       (addr),
      .func3      (func3),
      .flush      (flush),
      .stall_out  (stall_out),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_err   (load_err),
      .mem        (mif)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_err = 0;
   int          cfg_rdy = 0, cfg_rv = 0;
   logic [31:0] cfg_base = '0, cfg_w0 = '0, cfg_w1 = '0;
   bit          kill = 1'b0;

   // Memory model: accepts after cfg_rdy waiting cycles, answers cfg_rv cycles after the earliest slot.
   initial begin
      bit          pend, acc;
      int          wcnt, rcnt;
      logic [31:0] acc_addr;
      pend = 0; acc = 0; wcnt = 0; rcnt = 0; acc_addr = '0;
      mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
      forever begin
         @(negedge clk);
         mif.mem_ready = 1'b0;
         mif.mem_rvalid = 1'b0;
         if (kill) begin
            pend = 0; acc = 0; wcnt = 0; kill = 0;
         end
         if (acc) begin
            pend = 1; rcnt = 0; acc = 0;
         end
         if (pend) begin
            if (rcnt == cfg_rv) begin
               mif.mem_rvalid = 1'b1;
               mif.mem_rdata  = acc_addr == cfg_base ? cfg_w0 : cfg_w1;
               pend = 0;
            end else rcnt++;
         end else if (mif.mem_req) begin
            if (wcnt >= cfg_rdy) begin
               mif.mem_ready = 1'b1;
               acc = 1; acc_addr = mif.mem_addr; wcnt = 0;
            end else wcnt++;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic run_load(input logic [2:0] f3, input logic [31:0] a, output logic [31:0] d,
                           output logic e, output int lat, output int nreq,
                           output logic st_ok, output logic addr_ok);
      logic prev;
      @(negedge clk);
      load_req = 1'b1; func3 = f3; addr = a;
      #1 st_ok = stall_out;
      prev = 1'b0; nreq = 0; lat = 0; d = 'x; e = 1'bx; addr_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         load_req = 1'b0;
         lat++;
         if (load_valid) begin
            d = load_data; e = load_err; st_ok &= ~stall_out;
            return;
         end
         st_ok &= stall_out;
         if (mif.mem_req && !prev) begin
            nreq++;
            addr_ok &= mif.mem_addr == ({a[31:2], 2'b00} + (nreq == 2 ? 32'd4 : 32'd0));
         end
         prev = mif.mem_req;
      end
      lat = -1;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a, w0, w1;
      int          rdy, rv;
      logic [31:0] exp_d;
      logic        exp_e;
      int          exp_lat, exp_nreq;
   } vec_t;

   initial begin
      vec_t        v [13];
      logic [31:0] d;
      logic        e, st_ok, addr_ok, got;
      int          lat, nreq;

      v[0]  = '{F3_LB,  32'h103, 32'h80AABBCC, 32'h0, 0, 0, 32'hFFFFFF80, 1'b0, 3, 1};
      v[1]  = '{F3_LHU, 32'h102, 32'hBEEF1234, 32'h0, 0, 0, 32'h0000BEEF, 1'b0, 3, 1};
      v[2]  = '{F3_LH,  32'h102, 32'hBEEF1234, 32'h0, 0, 0, 32'hFFFFBEEF, 1'b0, 3, 1};
      v[3]  = '{F3_LW,  32'h100, 32'hBEEF1234, 32'h0, 0, 0, 32'hBEEF1234, 1'b0, 3, 1};
      v[4]  = '{F3_LBU, 32'h101, 32'h80AABBCC, 32'h0, 0, 0, 32'h000000BB, 1'b0, 3, 1};
      v[5]  = '{F3_LB,  32'h100, 32'h80AABBCC, 32'h0, 0, 0, 32'hFFFFFFCC, 1'b0, 3, 1};
      v[6]  = '{F3_LH,  32'h200, 32'h12348001, 32'h0, 0, 0, 32'hFFFF8001, 1'b0, 3, 1};
      v[7]  = '{3'b011, 32'h204, 32'h89ABCDEF, 32'h0, 0, 0, 32'h89ABCDEF, 1'b0, 3, 1};
`ifdef LOAD_MISALIGNED_SPLIT_EN
      v[8]  = '{F3_LW,  32'h101, 32'h44332211, 32'h88776655, 0, 0, 32'h55443322, 1'b0, 5, 2};
      v[9]  = '{F3_LH,  32'h101, 32'h11A2B3C4, 32'h0, 0, 0, 32'hFFFFA2B3, 1'b0, 3, 1};
      v[10] = '{F3_LHU, 32'h103, 32'h44332211, 32'h88776655, 0, 0, 32'h00005544, 1'b0, 5, 2};
`else
      v[8]  = '{F3_LW,  32'h101, 32'h44332211, 32'h88776655, 0, 0, 32'h0, 1'b1, 1, 0};
      v[9]  = '{F3_LH,  32'h101, 32'h11A2B3C4, 32'h0, 0, 0, 32'h0, 1'b1, 1, 0};
      v[10] = '{F3_LHU, 32'h103, 32'h44332211, 32'h88776655, 0, 0, 32'h0, 1'b1, 1, 0};
`endif
      v[11] = '{F3_LW,  32'h300, 32'hCAFEF00D, 32'h0, 4, 5, 32'hCAFEF00D, 1'b0, 12, 1};
      v[12] = '{F3_LBU, 32'h003, 32'h7F00FF00, 32'h0, 1, 2, 32'h0000007F, 1'b0, 6, 1};

      repeat (2) @(negedge clk);
      #1;
      chk("rst stall_out", 32'(stall_out), 32'h0);
      chk("rst mem_req", 32'(mif.mem_req), 32'h0);
      chk("rst mem_addr", mif.mem_addr, 32'h0);
      chk("rst load_valid", 32'(load_valid), 32'h0);
      chk("rst load_err", 32'(load_err), 32'h0);
      chk("rst load_data", load_data, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         cfg_base = {v[i].a[31:2], 2'b00}; cfg_w0 = v[i].w0; cfg_w1 = v[i].w1;
         cfg_rdy = v[i].rdy; cfg_rv = v[i].rv;
         run_load(v[i].f3, v[i].a, d, e, lat, nreq, st_ok, addr_ok);
         chk($sformatf("v%0d data", i), d, v[i].exp_d);
         chk($sformatf("v%0d err", i), 32'(e), 32'(v[i].exp_e));
         chk($sformatf("v%0d latency", i), lat, v[i].exp_lat);
         chk($sformatf("v%0d mem_req count", i), nreq, v[i].exp_nreq);
         chk($sformatf("v%0d stall", i), 32'(st_ok), 32'h1);
         chk($sformatf("v%0d mem_addr", i), 32'(addr_ok), 32'h1);
         @(negedge clk);
         chk($sformatf("v%0d valid pulse", i), 32'(load_valid), 32'h0);
      end

      // Flush in WAIT: the late response is dropped and the held result is untouched.
      cfg_base = 32'h500; cfg_w0 = 32'hDEADBEEF; cfg_rdy = 0; cfg_rv = 3;
      @(negedge clk); load_req = 1'b1; func3 = F3_LW; addr = 32'h500;
      @(negedge clk); load_req = 1'b0;
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("flush drain stall", 32'(stall_out), 32'h1);
      got = 1'b0;
      repeat (10) begin
         @(negedge clk);
         got |= load_valid;
      end
      chk("flush no valid", 32'(got), 32'h0);
      chk("flush data held", load_data, 32'h0000007F);
      chk("flush idle stall", 32'(stall_out), 32'h0);
      cfg_base = 32'h600; cfg_w0 = 32'h0BADF00D; cfg_rv = 0;
      run_load(F3_LW, 32'h600, d, e, lat, nreq, st_ok, addr_ok);
      chk("post-flush data", d, 32'h0BADF00D);
      chk("post-flush latency", lat, 3);

      // Reset in WAIT clears outputs at once and the late response completes nothing.
      @(negedge clk);
      cfg_base = 32'h700; cfg_w0 = 32'h12345678; cfg_rv = 6;
      @(negedge clk); load_req = 1'b1; func3 = F3_LW; addr = 32'h700;
      @(negedge clk); load_req = 1'b0;
      @(negedge clk); reset_n = 1'b0;
      #1;
      chk("mid rst stall_out", 32'(stall_out), 32'h0);
      chk("mid rst mem_req", 32'(mif.mem_req), 32'h0);
      chk("mid rst load_data", load_data, 32'h0);
      @(negedge clk); reset_n = 1'b1;
      got = 1'b0;
      repeat (10) begin
         @(negedge clk);
         got |= load_valid;
      end
      chk("mid rst no valid", 32'(got), 32'h0);

      // Response never comes: timeout after exactly 8 cycles in WAIT.
      cfg_base = 32'h400; cfg_rv = 1000;
      run_load(F3_LW, 32'h400, d, e, lat, nreq, st_ok, addr_ok);
      chk("timeout latency", lat, 10);
      chk("timeout err", 32'(e), 32'h1);
      chk("timeout data", d, 32'h0);
      kill = 1'b1;
      repeat (2) @(negedge clk);
      cfg_base = 32'h800; cfg_w0 = 32'hA5A5_0F0F; cfg_rv = 1;
      run_load(F3_LHU, 32'h800, d, e, lat, nreq, st_ok, addr_ok);
      chk("post-timeout data", d, 32'h00000F0F);
      chk("post-timeout err", 32'(e), 32'h0);
      chk("post-timeout latency", lat, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
